matmul_operand_feeder: RTL

- Transmit side of the systolic array's A/B operand interface.
- Accepts two full MAX_DIM x MAX_DIM operand matrices in one handshake, then drives diagonally skewed row/column streams onto the array's A and B buses.
- Generates the array's start_bit and mode_bit, waits for the array's done, and reports completion upstream.
- Sits between the operand register bank/APB slave and matmul array instance.

---
 rtl/matmul_operand_feeder.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/matmul_operand_feeder.sv
// Operand feeder for the systolic array: captures A/B, streams them diagonally skewed, then waits for the array's done.
// Optional watchdog on the WAIT state is enabled with `define MATMUL_FEEDER_TIMEOUT_EN (adds timeout_o).
module matmul_operand_feeder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BUS_WIDTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  output logic                     ready_o,
  input  logic                     mode_i,
  input  logic [DATA_WIDTH*(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)-1:0] a_mat_i,
  input  logic [DATA_WIDTH*(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)-1:0] b_mat_i,
  input  logic                     array_done_i,
  output logic [BUS_WIDTH-1:0]     a_o,
  output logic [BUS_WIDTH-1:0]     b_o,
  output logic                     start_bit_o,
  output logic                     mode_bit_o,
  output logic                     busy_o,
  output logic [$clog2(3*(BUS_WIDTH/DATA_WIDTH)-2)-1:0] cycle_o,
  output logic                     done_o
`ifdef MATMUL_FEEDER_TIMEOUT_EN
  ,
  output logic                     timeout_o
`endif
);

  localparam int unsigned MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int unsigned MAT_W   = DATA_WIDTH * MAX_DIM * MAX_DIM;
  localparam int unsigned CYC_W   = $clog2(3 * MAX_DIM - 2);
  localparam int unsigned LAST_K  = 2 * MAX_DIM - 2;
`ifdef MATMUL_FEEDER_TIMEOUT_EN
  localparam int unsigned WD_W    = $clog2(4 * MAX_DIM);
  localparam int unsigned WD_LAST = 4 * MAX_DIM - 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [MAT_W-1:0]     r_a_mat;
  logic [MAT_W-1:0]     r_b_mat;
  logic [BUS_WIDTH-1:0] r_a;
  logic [BUS_WIDTH-1:0] r_b;
  logic [CYC_W-1:0]     r_cycle;
  logic                 r_ready;
  logic                 r_start_bit;
  logic                 r_mode_bit;
  logic                 r_busy;
  logic                 r_done;
`ifdef MATMUL_FEEDER_TIMEOUT_EN
  logic [WD_W-1:0]      r_wd;
  logic                 r_timeout;
`endif

  logic [CYC_W-1:0]     w_cycle_nxt;
  logic [BUS_WIDTH-1:0] w_a_first;
  logic [BUS_WIDTH-1:0] w_b_first;
  logic [BUS_WIDTH-1:0] w_a_nxt;
  logic [BUS_WIDTH-1:0] w_b_nxt;

  // Lane l at step k carries the element whose skew offset e satisfies k == l + e:
  // A[l][e] for rows (col=0), B[e][l] for columns (col=1); lanes without one are zero.
  function automatic logic [BUS_WIDTH-1:0] skew_slice(input logic [MAT_W-1:0] m,
                                                      input logic [CYC_W-1:0] k,
                                                      input logic             col);
    logic [BUS_WIDTH-1:0] v;
    v = '0;
    for (int l = 0; l < int'(MAX_DIM); l++) begin
      for (int e = 0; e < int'(MAX_DIM); e++) begin
        if (int'(k) == l + e) begin
          if (col) v[l*DATA_WIDTH +: DATA_WIDTH] = m[(e*MAX_DIM+l)*DATA_WIDTH +: DATA_WIDTH];
          else     v[l*DATA_WIDTH +: DATA_WIDTH] = m[(l*MAX_DIM+e)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
    return v;
  endfunction

  always_comb begin
    w_cycle_nxt = r_cycle + CYC_W'(1);
    w_a_first   = skew_slice(a_mat_i, CYC_W'(0), 1'b0);
    w_b_first   = skew_slice(b_mat_i, CYC_W'(0), 1'b1);
    w_a_nxt     = skew_slice(r_a_mat, w_cycle_nxt, 1'b0);
    w_b_nxt     = skew_slice(r_b_mat, w_cycle_nxt, 1'b1);
  end

  // Sequencer: every output is a register updated alongside the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_a_mat     <= '0;
      r_b_mat     <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_cycle     <= '0;
      r_ready     <= 1'b1;
      r_start_bit <= 1'b0;
      r_mode_bit  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef MATMUL_FEEDER_TIMEOUT_EN
      r_wd        <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_a_mat     <= a_mat_i;
            r_b_mat     <= b_mat_i;
            r_a         <= w_a_first;
            r_b         <= w_b_first;
            r_cycle     <= '0;
            r_mode_bit  <= mode_i;
            r_start_bit <= 1'b1;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_FEED;
          end
        end
        S_FEED: begin
          r_start_bit <= 1'b0;
          if (r_cycle == CYC_W'(LAST_K)) begin
            r_a     <= '0;
            r_b     <= '0;
            r_state <= S_WAIT;
`ifdef MATMUL_FEEDER_TIMEOUT_EN
            r_wd    <= '0;
`endif
          end else begin
            r_cycle <= w_cycle_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
          end
        end
        S_WAIT: begin
          if (array_done_i) begin
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_mode_bit <= 1'b0;
            r_state    <= S_DONE;
          end
`ifdef MATMUL_FEEDER_TIMEOUT_EN
          else if (r_wd == WD_W'(WD_LAST)) begin
            r_done     <= 1'b1;
            r_timeout  <= 1'b1;
            r_busy     <= 1'b0;
            r_mode_bit <= 1'b0;
            r_state    <= S_DONE;
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
`endif
        end
        S_DONE: begin
          r_done    <= 1'b0;
          r_ready   <= 1'b1;
          r_state   <= S_IDLE;
`ifdef MATMUL_FEEDER_TIMEOUT_EN
          r_timeout <= 1'b0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o     = r_ready;
  assign a_o         = r_a;
  assign b_o         = r_b;
  assign start_bit_o = r_start_bit;
  assign mode_bit_o  = r_mode_bit;
  assign busy_o      = r_busy;
  assign cycle_o     = r_cycle;
  assign done_o      = r_done;
`ifdef MATMUL_FEEDER_TIMEOUT_EN
  assign timeout_o   = r_timeout;
`endif

endmodule
